// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry, LSB first.
// Optional subtract mode when SERIAL_ADDER_SUB_EN is defined (adds port sub).
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             s;
  logic             c;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is a + ~b + 1; cin is ignored while subtracting
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (c)
  );

  // bit 0 of the shifted result only ever feeds the final sum
  assign res_nxt = {s, res_sh};
  assign last    = (cnt == LAST);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b_load;
            carry  <= c_load;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        (state_q == RUN): begin
          carry  <= c;
          res_sh <= res_nxt[WIDTH-1:1];
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (last) begin
            sum  <= res_nxt;
            cout <= c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
